conv_window_sequencer: RTL and testbench

Runtime-configurable sequencer for the 3x3 line-buffer window datapath. It takes a raster pixel stream and drives the buffer's shift enable. It also generates zero-fill flush shifts at end of frame, and qualifies each 3x3 window with output_valid and a 9-bit pad mask. Stride (1/2) and padding (0/1) are latched per frame, so one line buffer serves every conv layer without resynthesis.

---
 rtl/conv_window_sequencer_if.sv | 24 ++
 rtl/conv_window_sequencer.sv | 112 +++++++++++
 tb/tb_conv_window_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/conv_window_sequencer_if.sv
// conv_window_sequencer_if: pixel-stream, line-buffer control and window qualifier bundle (err_sof_abort with CONV_SEQ_ERR_EN)
interface conv_window_sequencer_if #(parameter int CW = 8);
  logic sof, input_valid, cfg_stride2, cfg_pad;
  logic in_ready, load, zero_fill, busy, output_valid, last_win;
  logic [8:0] is_pad;
  logic [CW-1:0] cx, cy;
`ifdef CONV_SEQ_ERR_EN
  logic err_sof_abort;
`endif
  modport master(
    output sof, input_valid, cfg_stride2, cfg_pad,
    input in_ready, load, zero_fill, busy, output_valid, is_pad, cx, cy, last_win
`ifdef CONV_SEQ_ERR_EN
    , input err_sof_abort
`endif
  );
  modport slave(
    input sof, input_valid, cfg_stride2, cfg_pad,
    output in_ready, load, zero_fill, busy, output_valid, is_pad, cx, cy, last_win
`ifdef CONV_SEQ_ERR_EN
    , output err_sof_abort
`endif
  );
endinterface

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: 3x3 line-buffer shift/flush sequencer with runtime stride/pad window qualification
// Optional sticky err_sof_abort output when CONV_SEQ_ERR_EN is defined.
module conv_window_sequencer #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int CW = 8
) (
  input logic clk,
  input logic rst,
  conv_window_sequencer_if.slave bus
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int SW = $clog2(NPIX + IMG_W + 2);
  localparam int YW = CW + 2;
  localparam logic [CW-1:0] XMAX = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LX0 = CW'(IMG_W - 2);
  localparam logic [CW-1:0] LX1 = CW'((((IMG_W - 2) % 2) == 1) ? IMG_W - 2 : IMG_W - 3);
  localparam logic [CW-1:0] LX2 = CW'(IMG_W - 1);
  localparam logic [CW-1:0] LX3 = CW'((((IMG_W - 1) % 2) == 0) ? IMG_W - 1 : IMG_W - 2);
  localparam logic signed [YW-1:0] YMAX = YW'(IMG_H - 1);
  localparam logic signed [YW-1:0] YMAX1 = YW'(IMG_H - 2);
  localparam logic signed [YW-1:0] YINIT = YW'(-2);
  localparam logic signed [YW-1:0] Y0 = YW'(0);
  localparam logic signed [YW-1:0] Y1 = YW'(1);
  localparam logic signed [YW-1:0] LY0 = YW'(IMG_H - 2);
  localparam logic signed [YW-1:0] LY1 = YW'((((IMG_H - 2) % 2) == 1) ? IMG_H - 2 : IMG_H - 3);
  localparam logic signed [YW-1:0] LY2 = YW'(IMG_H - 1);
  localparam logic signed [YW-1:0] LY3 = YW'((((IMG_H - 1) % 2) == 0) ? IMG_H - 1 : IMG_H - 2);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;
  state_t state, state_n;
  logic [SW-1:0] s, cs;
  logic [CW-1:0] wx, ccx, nx, lx;
  logic signed [YW-1:0] wy, ccy, ny, ly;
  logic stride2, pad, accept, sof_acc, x_ok, y_ok, grid, win, at_last, flush_done;
  logic top, bot, lft, rgt;
  logic [8:0] pad_mask;

  assign bus.in_ready = state != FLUSH;
  assign bus.zero_fill = state == FLUSH;
  assign bus.busy = state == FLUSH;
  assign sof_acc = bus.input_valid && bus.sof && state != FLUSH;
  assign accept = bus.input_valid && state != FLUSH && (state == ACTIVE || bus.sof);
  assign bus.load = accept || state == FLUSH;

  // (wx,wy) is the centre completed by the next shift; a new frame starts at (IMG_W-1,-2)
  always_comb begin
    cs = sof_acc ? '0 : s;
    ccx = sof_acc ? XMAX : wx;
    ccy = sof_acc ? YINIT : wy;
    nx = (ccx == XMAX) ? '0 : ccx + 1'b1;
    ny = (ccx == XMAX) ? ccy + 1'b1 : ccy;
    x_ok = pad || (ccx != '0 && ccx != XMAX);
    y_ok = pad ? (ccy >= Y0 && ccy <= YMAX) : (ccy >= Y1 && ccy <= YMAX1);
    grid = !stride2 || (ccx[0] == !pad && ccy[0] == !pad);
    win = x_ok && y_ok && grid;
    lx = pad ? (stride2 ? LX3 : LX2) : (stride2 ? LX1 : LX0);
    ly = pad ? (stride2 ? LY3 : LY2) : (stride2 ? LY1 : LY0);
    top = ccy == Y0;
    bot = ccy == YMAX;
    lft = ccx == '0;
    rgt = ccx == XMAX;
    pad_mask = pad ? {bot | rgt, bot, bot | lft, rgt, 1'b0, lft, top | rgt, top, top | lft} : 9'h000;
    at_last = cs == SW'(NPIX - 1);
    flush_done = s == SW'(NPIX + IMG_W);
    state_n = state;
    if (state == FLUSH) state_n = flush_done ? IDLE : FLUSH;
    else if (accept) state_n = at_last ? (pad ? FLUSH : IDLE) : ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s <= '0;
      wx <= '0;
      wy <= '0;
      stride2 <= 1'b0;
      pad <= 1'b0;
      bus.output_valid <= 1'b0;
      bus.is_pad <= '0;
      bus.cx <= '0;
      bus.cy <= '0;
      bus.last_win <= 1'b0;
    end else begin
      state <= state_n;
      if (sof_acc) begin
        stride2 <= bus.cfg_stride2;
        pad <= bus.cfg_pad;
      end
      if (bus.load) begin
        s <= cs + 1'b1;
        wx <= nx;
        wy <= ny;
      end
      bus.output_valid <= bus.load && win;
      if (bus.load && win) begin
        bus.is_pad <= pad_mask;
        bus.cx <= ccx;
        bus.cy <= ccy[CW-1:0];
        bus.last_win <= ccx == lx && ccy == ly;
      end
    end
  end

`ifdef CONV_SEQ_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) bus.err_sof_abort <= 1'b0;
    else if ((sof_acc && state == ACTIVE && s != '0) || (state == FLUSH && bus.sof && bus.input_valid))
      bus.err_sof_abort <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb_conv_window_sequencer: table-driven frame vectors plus abort and reset-in-flush sequences
module tb_conv_window_sequencer;
  localparam int W = 5, H = 5, CW = 8;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  conv_window_sequencer_if #(.CW(CW)) bus();
  conv_window_sequencer #(.IMG_W(W), .IMG_H(H), .CW(CW)) dut(.clk(clk), .rst(rst), .bus(bus));

  typedef struct {logic [CW-1:0] x, y; logic [8:0] p; logic l;} win_t;
  typedef struct {bit s2, pd, tog; int cnt, fl; logic [8:0] fp, lp;} vec_t;
  win_t q[$];
  vec_t tbl[4];
  int checks = 0, errors = 0;
  int busy_cnt = 0, flush_bad = 0, ovl_bad = 0;
  logic prev_load = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] exp_pad(input int x, input int y, input bit pd);
    logic [8:0] m = 9'h000;
    if (!pd) return m;
    if (y == 0) m |= 9'h007;
    if (y == H - 1) m |= 9'h1C0;
    if (x == 0) m |= 9'h049;
    if (x == W - 1) m |= 9'h124;
    return m;
  endfunction

  always @(negedge clk) if (!rst) begin
    if (bus.busy) begin
      busy_cnt++;
      if (bus.in_ready || !bus.zero_fill || !bus.load) flush_bad++;
    end
    if (bus.output_valid) begin
      if (!prev_load) ovl_bad++;
      q.push_back('{bus.cx, bus.cy, bus.is_pad, bus.last_win});
    end
    prev_load = bus.load;
  end

  task automatic clr();
    q.delete();
    busy_cnt = 0;
    flush_bad = 0;
    ovl_bad = 0;
  endtask

  task automatic feed(input int n, input bit s2, input bit pd, input bit tog);
    int k = 0, cyc = 0;
    while (k < n && cyc < 400) begin
      bus.input_valid = !tog || (cyc % 2 == 1);
      bus.sof = (k == 0);
      bus.cfg_stride2 = (k == 0) ? s2 : !s2;
      bus.cfg_pad = (k == 0) ? pd : !pd;
      @(posedge clk); #1;
      if (bus.input_valid) k++;
      cyc++;
    end
    chk("feed_budget", k, n);
    bus.input_valid = 1'b0;
    bus.sof = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("idle_timeout_busy", int'(bus.busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_frame(input string nm, input bit s2, input bit pd, input int ecnt,
                             input int efl, input logic [8:0] fp, input logic [8:0] lp);
    int i = 0;
    int lo = pd ? 0 : 1;
    int hi = pd ? W - 1 : W - 2;
    int st = s2 ? 2 : 1;
    chk({nm, "_count"}, q.size(), ecnt);
    chk({nm, "_flush_cycles"}, busy_cnt, efl);
    chk({nm, "_flush_bad"}, flush_bad, 0);
    chk({nm, "_valid_wo_load"}, ovl_bad, 0);
    if (q.size() > 0) begin
      chk({nm, "_first_pad"}, int'(q[0].p), int'(fp));
      chk({nm, "_last_pad"}, int'(q[q.size()-1].p), int'(lp));
    end
    for (int y = lo; y <= hi; y += st)
      for (int x = lo; x <= hi; x += st) begin
        if (i < q.size()) begin
          chk({nm, "_cx"}, int'(q[i].x), x);
          chk({nm, "_cy"}, int'(q[i].y), y);
          chk({nm, "_pad"}, int'(q[i].p), int'(exp_pad(x, y, pd)));
          chk({nm, "_last"}, int'(q[i].l), int'(i == ecnt - 1));
        end
        i++;
      end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 0, 0, 9, 0, 9'h000, 9'h000};
    tbl[1] = '{1, 0, 0, 4, 0, 9'h000, 9'h000};
    tbl[2] = '{0, 1, 0, 25, 6, 9'h04F, 9'h1E4};
    tbl[3] = '{1, 1, 1, 9, 6, 9'h04F, 9'h1E4};
    bus.sof = 1'b0;
    bus.input_valid = 1'b0;
    bus.cfg_stride2 = 1'b0;
    bus.cfg_pad = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_load", int'(bus.load), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_zero_fill", int'(bus.zero_fill), 0);
    chk("rst_output_valid", int'(bus.output_valid), 0);
    chk("rst_is_pad", int'(bus.is_pad), 0);
    chk("rst_last_win", int'(bus.last_win), 0);
    @(posedge clk); #1;
    bus.input_valid = 1'b1;
    @(negedge clk);
    chk("idle_no_sof_load", int'(bus.load), 0);
    @(posedge clk); #1;
    bus.input_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_sof_windows", q.size(), 0);
    for (int v = 0; v < 4; v++) begin
      clr();
      feed(W * H, tbl[v].s2, tbl[v].pd, tbl[v].tog);
      wait_idle();
      check_frame($sformatf("vec%0d", v), tbl[v].s2, tbl[v].pd, tbl[v].cnt, tbl[v].fl, tbl[v].fp, tbl[v].lp);
    end
`ifdef CONV_SEQ_ERR_EN
    chk("err_clean", int'(bus.err_sof_abort), 0);
`endif
    clr();
    feed(14, 0, 0, 0);
    @(posedge clk); #1;
    chk("abort_old_windows", q.size(), 2);
    clr();
    feed(W * H, 1, 1, 0);
    wait_idle();
    check_frame("abort", 1, 1, 9, 6, 9'h04F, 9'h1E4);
`ifdef CONV_SEQ_ERR_EN
    chk("err_abort", int'(bus.err_sof_abort), 1);
`endif
    clr();
    feed(W * H, 0, 1, 0);
    chk("flush_entered", int'(bus.busy), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstflush_load", int'(bus.load), 0);
    chk("rstflush_busy", int'(bus.busy), 0);
    chk("rstflush_output_valid", int'(bus.output_valid), 0);
    chk("rstflush_in_ready", int'(bus.in_ready), 1);
    chk("rstflush_zero_fill", int'(bus.zero_fill), 0);
    @(posedge clk); #1;
    clr();
    feed(W * H, 0, 0, 0);
    wait_idle();
    check_frame("after_rst", 0, 0, 9, 0, 9'h000, 9'h000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
